// File: rtl/gelu_pkg.sv
// gelu_pkg -- shared parameters, fixed-point constants and lane type for the
// streaming GELU unit.
//   LANES/DW/SF : lane count, lane width, scale fraction bits (Q8.24)
//   ZW/PW       : working width of signed Q.24 intermediates and their products
//   ONE, HALF, INV_SQRT2, ERF_A, ERF_B : Q8.24 constants of the erf polynomial
//   lane_t      : signed int8 lane
package gelu_pkg;

   localparam int LANES = 32;
   localparam int DW    = 8;
   localparam int SF    = 24;
   localparam int BW    = LANES * DW;
   localparam int ZW    = 48;
   localparam int PW    = 2 * ZW;

   localparam logic signed [31:0] ONE       = 32'sh0100_0000;
   localparam logic signed [31:0] HALF      = 32'sh0080_0000;
   localparam logic signed [31:0] INV_SQRT2 = 32'sh00B5_04F3;
   localparam logic signed [31:0] ERF_A     = -32'sd4845260;   // -0.2888
   localparam logic signed [31:0] ERF_B     = 32'sd29678895;   //  1.769

   typedef logic signed [DW-1:0] lane_t;

endpackage

// File: rtl/gelu_if.sv
// gelu_if -- valid/ready stream bundle between FC1 output path, GELU unit and
// activation write-back.
//   data_in_valid/ready, in_data, in_scale, out_scale : input beat side
//   data_out_valid/ready, out_data                    : output beat side
//   master : producer/consumer (testbench) view; slave : gelu_unit view
interface gelu_if;

   logic                     data_in_valid;
   logic                     data_in_ready;
   logic [gelu_pkg::BW-1:0]  in_data;
   logic [31:0]              in_scale;
   logic [31:0]              out_scale;
   logic                     data_out_valid;
   logic                     data_out_ready;
   logic [gelu_pkg::BW-1:0]  out_data;

   modport master (
      output data_in_valid, in_data, in_scale, out_scale, data_out_ready,
      input  data_in_ready, data_out_valid, out_data
   );

   modport slave (
      input  data_in_valid, in_data, in_scale, out_scale, data_out_ready,
      output data_in_ready, data_out_valid, out_data
   );

endinterface

// File: rtl/gelu_lane.sv
// gelu_lane -- one int8 lane of the 3-stage GELU datapath.
//   clk, rst   : clock, asynchronous active-high reset
//   en_stg[0]  : load stage-1 registers (beat accepted)
//   en_stg[1]  : load stage-2 registers
//   en_stg[2]  : load output register
//   x, in_scale: activation and its Q8.24 scale, sampled with the beat
//   out_scale  : Q8.24 inverse output scale aligned with stage-2 contents
//   y          : requantised int8 GELU result
//   sat        : y was clipped (only with GELU_SAT_CNT_EN)
module gelu_lane
   import gelu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  en_stg,
   input  lane_t       x,
   input  logic [31:0] in_scale,
   input  logic [31:0] out_scale,
`ifdef GELU_SAT_CNT_EN
   output logic        sat,
`endif
   output lane_t       y
);

   logic signed [ZW-1:0] z1_d, z1_q, u1_d, u1_q;
   logic signed [ZW-1:0] z2_d, z2_q, e2_d, e2_q;
   lane_t                y_d, y_q;
   logic                 sat_d;

   logic        [ZW-1:0] z_mag;
   logic        [PW-1:0] u_prod;
   logic signed [ZW-1:0] c, d, d2, l, ope, hope, g;
   logic signed [PW-1:0] d2_prod, a_prod, hope_prod, g_prod, y_prod;
   logic        [PW-1:0] y_mag, r;
   logic                 y_neg, pos_ovf, neg_ovf;

   // NOTE: every variable gets its value on every pass through this block
   // (computed in order, no conditional-only writes), so no latch is inferred.
   always_comb begin
      // Stage 1: z = x*s_in, u = |z|/sqrt2
      z1_d   = ZW'(x) * ZW'($signed({1'b0, in_scale}));
      z_mag  = z1_d[ZW-1] ? -z1_d : z1_d;
      u_prod = PW'(z_mag) * PW'(INV_SQRT2);
      u1_d   = ZW'(u_prod >> SF);

      // Stage 2: clipped polynomial erf, L = 1 + a*(c-b)^2
      c       = (u1_q > ZW'(ERF_B)) ? ZW'(ERF_B) : u1_q;
      d       = c - ZW'(ERF_B);
      d2_prod = PW'(d) * PW'(d);
      d2      = ZW'(d2_prod >>> SF);
      a_prod  = PW'(d2) * PW'(ERF_A);
      l       = ZW'(ONE) + ZW'(a_prod >>> SF);
      z2_d    = z1_q;
      e2_d    = z1_q[ZW-1] ? -l : l;

      // Stage 3: g = z*0.5*(1+e), y = g/s_out, round half away from zero
      ope       = ZW'(ONE) + e2_q;
      hope_prod = PW'(ope) * PW'(HALF);
      hope      = ZW'(hope_prod >>> SF);
      g_prod    = PW'(z2_q) * PW'(hope);
      g         = ZW'(g_prod >>> SF);
      y_prod    = PW'(g) * PW'($signed({1'b0, out_scale}));
      y_neg     = y_prod[PW-1];
      y_mag     = y_neg ? -y_prod : y_prod;
      // y_prod carries 2*SF fraction bits; add one half LSB before truncating
      r         = (y_mag + (PW'(1) << (2*SF-1))) >> (2*SF);
      pos_ovf   = !y_neg && (r > PW'(127));
      neg_ovf   = y_neg && (r > PW'(128));
      sat_d     = pos_ovf || neg_ovf;
      if (pos_ovf)      y_d = 8'sh7F;
      else if (neg_ovf) y_d = 8'sh80;
      else if (y_neg)   y_d = DW'(-r);
      else              y_d = DW'(r);
   end

   // NOTE: stage-1/2 data flops have no reset; the valid pipeline in the top
   // decides whether their contents mean anything.
   always_ff @(posedge clk) begin
      if (en_stg[0]) begin
         z1_q <= z1_d;
         u1_q <= u1_d;
      end
      if (en_stg[1]) begin
         z2_q <= z2_d;
         e2_q <= e2_d;
      end
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            y_q <= '0;
      else if (en_stg[2]) y_q <= y_d;
   end

   assign y = y_q;

`ifdef GELU_SAT_CNT_EN
   logic sat_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            sat_q <= 1'b0;
      else if (en_stg[2]) sat_q <= sat_d;
   end
   assign sat = sat_q;
`endif

endmodule

// File: rtl/gelu_unit.sv
// gelu_unit -- streaming element-wise GELU, 32 int8 lanes per 256-bit beat,
// 3-cycle latency, 1 beat/cycle, whole pipeline stalls on output backpressure.
//   clk, rst   : clock, asynchronous active-high reset
//   io         : gelu_if.slave stream (input beat + scales, output beat)
//   sat_count  : 16-bit saturating count of clipped lanes, present only when
//                the macro GELU_SAT_CNT_EN is defined
module gelu_unit
   import gelu_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
`ifdef GELU_SAT_CNT_EN
   output logic [15:0]  sat_count,
`endif
   gelu_if.slave        io
);

   logic        adv;
   logic        v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
   logic [31:0] os1_d, os1_q, os2_d, os2_q;
   logic [2:0]  en_stg;
   logic [BW-1:0]    out_data_w;
   logic [LANES-1:0] lane_sat;

   always_comb begin
      // Everything moves together unless a valid output is being held.
      adv  = !v3_q || io.data_out_ready;
      v1_d = v1_q;
      v2_d = v2_q;
      v3_d = v3_q;
      if (adv) begin
         v1_d = io.data_in_valid;
         v2_d = v1_q;
         v3_d = v2_q;
      end
      en_stg = {adv && v2_q, adv && v1_q, adv && io.data_in_valid};
      // Output scale rides along with its beat up to stage 3.
      os1_d  = en_stg[0] ? io.out_scale : os1_q;
      os2_d  = en_stg[1] ? os1_q : os2_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         v3_q <= v3_d;
      end
   end

   always_ff @(posedge clk) begin
      os1_q <= os1_d;
      os2_q <= os2_d;
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      gelu_lane u_lane (
         .clk       (clk),
         .rst       (rst),
         .en_stg    (en_stg),
         .x         (io.in_data[DW*i +: DW]),
         .in_scale  (io.in_scale),
         .out_scale (os2_q),
`ifdef GELU_SAT_CNT_EN
         .sat       (lane_sat[i]),
`endif
         .y         (out_data_w[DW*i +: DW])
      );
   end

   assign io.data_in_ready  = adv;
   assign io.data_out_valid = v3_q;
   assign io.out_data       = out_data_w;

`ifdef GELU_SAT_CNT_EN
   logic [15:0] sat_cnt_d, sat_cnt_q;
   logic [16:0] sat_sum;

   always_comb begin
      sat_sum = {1'b0, sat_cnt_q};
      for (int i = 0; i < LANES; i++) sat_sum = sat_sum + 17'(lane_sat[i]);
      sat_cnt_d = sat_cnt_q;
      if (v3_q && io.data_out_ready) sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sat_cnt_q <= '0;
      else     sat_cnt_q <= sat_cnt_d;
   end

   assign sat_count = sat_cnt_q;
`else
   // Clip flags stay inside the lanes; nothing consumes them here.
   assign lane_sat = '0;
`endif

endmodule

// File: tb/tb_gelu_unit.sv
// tb_gelu_unit -- directed self-checking bench for gelu_unit.
module tb_gelu_unit;
   import gelu_pkg::*;

   localparam logic [31:0] S16  = 32'h0010_0000;  // 1/16
   localparam logic [31:0] S1   = 32'h0100_0000;  // 1.0
   localparam logic [31:0] OS16 = 32'h1000_0000;  // 16
   localparam logic [31:0] OS8  = 32'h0800_0000;  // 8

   logic clk = 1'b0;
   logic rst;
   gelu_if io ();
`ifdef GELU_SAT_CNT_EN
   logic [15:0] sat_count;
   int          sat_exp = 0;
`endif

   gelu_unit dut (
      .clk       (clk),
      .rst       (rst),
`ifdef GELU_SAT_CNT_EN
      .sat_count (sat_count),
`endif
      .io        (io)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Hand-computed results at in_scale 1/16, out_scale 16.
   logic [7:0] tbl_x [6] = '{8'h00, 8'h7F, 8'h80, 8'h20, 8'hE0, 8'h10};
   logic [7:0] tbl_y [6] = '{8'h00, 8'h7F, 8'h00, 8'h1F, 8'hFF, 8'h0D};

   function automatic logic [BW-1:0] splat(input logic [7:0] b);
      return {LANES{b}};
   endfunction

   function automatic logic [BW-1:0] mix_x(input int k);
      logic [BW-1:0] v;
      for (int i = 0; i < LANES; i++) v[DW*i +: DW] = tbl_x[(i + k) % 6];
      return v;
   endfunction

   function automatic logic [BW-1:0] mix_y(input int k);
      logic [BW-1:0] v;
      for (int i = 0; i < LANES; i++) v[DW*i +: DW] = tbl_y[(i + k) % 6];
      return v;
   endfunction

   task automatic idle_inputs();
      io.data_in_valid  = 1'b0;
      io.in_data        = '0;
      io.in_scale       = S16;
      io.out_scale      = OS16;
      io.data_out_ready = 1'b1;
   endtask

   // Send one beat into an empty pipeline and wait for its result.
   // lat counts rising edges from the accepting edge to valid output.
   task automatic run_beat(input logic [BW-1:0] d, input logic [31:0] si,
                           input logic [31:0] so, output logic [BW-1:0] got,
                           output int lat);
      @(negedge clk);
      io.data_in_valid = 1'b1;
      io.in_data       = d;
      io.in_scale      = si;
      io.out_scale     = so;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      io.data_in_valid = 1'b0;
      while (!io.data_out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      got = io.out_data;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (3) @(negedge clk);
      checks++;
      if ({io.data_out_valid, io.out_data} !== {1'b0, {BW{1'b0}}}) begin
         errors++;
         $display("FAIL reset_out: valid=%b data=%h required valid=0 data=0", io.data_out_valid, io.out_data);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (io.data_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b required 1", io.data_in_ready);
      end
`ifdef GELU_SAT_CNT_EN
      checks++;
      if (sat_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_sat_count: got %0d required 0", sat_count);
      end
`endif
   endtask

   task automatic test_zero_identity();
      logic [BW-1:0] got;
      int lat;
      for (int k = 0; k < 3; k++) begin
         run_beat(splat(tbl_x[k]), S16, OS16, got, lat);
         checks++;
         if (got !== splat(tbl_y[k])) begin
            errors++;
            $display("FAIL identity_x%h: got %h required %h", tbl_x[k], got, splat(tbl_y[k]));
         end
         checks++;
         if (lat !== 3) begin
            errors++;
            $display("FAIL latency_x%h: got %0d cycles required 3", tbl_x[k], lat);
         end
      end
   endtask

   task automatic test_curve();
      logic [BW-1:0] got;
      int lat;
      for (int k = 3; k < 6; k++) begin
         run_beat(splat(tbl_x[k]), S16, OS16, got, lat);
         checks++;
         if (got !== splat(tbl_y[k])) begin
            errors++;
            $display("FAIL curve_x%h: got %h required %h", tbl_x[k], got, splat(tbl_y[k]));
         end
      end
      run_beat(mix_x(0), S16, OS16, got, lat);
      checks++;
      if (got !== mix_y(0)) begin
         errors++;
         $display("FAIL lane_order: got %h required %h", got, mix_y(0));
      end
   endtask

   task automatic test_scale_change();
      @(negedge clk);
      io.data_in_valid = 1'b1;
      io.in_data       = splat(8'h20);
      io.out_scale     = OS16;
      @(negedge clk);
      io.out_scale     = OS8;
      @(negedge clk);
      io.data_in_valid = 1'b0;
      io.out_scale     = OS16;
      @(negedge clk);
      checks++;
      if ({io.data_out_valid, io.out_data} !== {1'b1, splat(8'h1F)}) begin
         errors++;
         $display("FAIL scale_beat_a: valid=%b data=%h required valid=1 data=%h", io.data_out_valid, io.out_data, splat(8'h1F));
      end
      @(negedge clk);
      checks++;
      if ({io.data_out_valid, io.out_data} !== {1'b1, splat(8'h10)}) begin
         errors++;
         $display("FAIL scale_beat_b: valid=%b data=%h required valid=1 data=%h", io.data_out_valid, io.out_data, splat(8'h10));
      end
   endtask

   task automatic test_backpressure();
      logic          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [BW-1:0] held;
      logic          holding = 1'b0;
      int            sent = 0;
      int            rcvd = 0;
      int            cyc  = 0;
      bit            extra = 1'b0;
      while (rcvd < 10 && cyc < 200) begin
         @(negedge clk);
         if (holding) begin
            checks++;
            if ({io.data_out_valid, io.out_data} !== {1'b1, held}) begin
               errors++;
               $display("FAIL bp_stable: valid=%b data=%h required valid=1 data=%h", io.data_out_valid, io.out_data, held);
            end
         end
         io.data_out_ready = pat[cyc % 4];
         io.data_in_valid  = (sent < 10);
         io.in_data        = mix_x(sent);
         io.in_scale       = S16;
         io.out_scale      = OS16;
         #1;
         if (io.data_out_valid && !io.data_out_ready) begin
            checks++;
            if (io.data_in_ready !== 1'b0) begin
               errors++;
               $display("FAIL bp_in_ready: got %b required 0 during stall", io.data_in_ready);
            end
         end
         if (io.data_out_valid && io.data_out_ready) begin
            checks++;
            if (io.out_data !== mix_y(rcvd)) begin
               errors++;
               $display("FAIL bp_beat%0d: got %h required %h", rcvd, io.out_data, mix_y(rcvd));
            end
            rcvd++;
         end
         holding = io.data_out_valid && !io.data_out_ready;
         held    = io.out_data;
         if (io.data_in_valid && io.data_in_ready) sent++;
         cyc++;
      end
      idle_inputs();
      checks++;
      if (rcvd != 10) begin
         errors++;
         $display("FAIL bp_timeout: received %0d beats required 10", rcvd);
      end
      repeat (5) begin
         @(negedge clk);
         if (io.data_out_valid) extra = 1'b1;
      end
      checks++;
      if (extra) begin
         errors++;
         $display("FAIL bp_duplicate: valid=1 seen after all beats required 0");
      end
   endtask

   task automatic test_reset_midstream();
      logic [BW-1:0] got;
      int lat;
      bit stale = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         io.data_in_valid = 1'b1;
         io.in_data       = mix_x(k);
      end
      @(negedge clk);
      io.data_in_valid = 1'b0;
      checks++;
      if (io.data_out_valid !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre_valid: got %b required 1", io.data_out_valid);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({io.data_out_valid, io.out_data} !== {1'b0, {BW{1'b0}}}) begin
         errors++;
         $display("FAIL rst_async: valid=%b data=%h required valid=0 data=0", io.data_out_valid, io.out_data);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (io.data_out_valid) stale = 1'b1;
      end
      checks++;
      if (stale) begin
         errors++;
         $display("FAIL rst_stale: valid=1 seen after release required 0");
      end
      run_beat(mix_x(2), S16, OS16, got, lat);
      checks++;
      if (got !== mix_y(2) || lat !== 3) begin
         errors++;
         $display("FAIL rst_first_beat: got %h lat %0d required %h lat 3", got, lat, mix_y(2));
      end
   endtask

   task automatic test_saturation();
      logic [BW-1:0] got, xv, yv;
      int lat;
      run_beat(splat(8'd100), S1, OS16, got, lat);
      checks++;
      if (got !== splat(8'h7F)) begin
         errors++;
         $display("FAIL sat_all: got %h required %h", got, splat(8'h7F));
      end
      @(negedge clk);
`ifdef GELU_SAT_CNT_EN
      sat_exp += 32;
      checks++;
      if (sat_count !== 16'(sat_exp)) begin
         errors++;
         $display("FAIL sat_count_all: got %0d required %0d", sat_count, sat_exp);
      end
`endif
      for (int i = 0; i < LANES; i++) begin
         xv[DW*i +: DW] = (i % 2 == 0) ? 8'd100 : 8'd0;
         yv[DW*i +: DW] = (i % 2 == 0) ? 8'h7F : 8'h00;
      end
      run_beat(xv, S1, OS16, got, lat);
      checks++;
      if (got !== yv) begin
         errors++;
         $display("FAIL sat_mixed: got %h required %h", got, yv);
      end
      @(negedge clk);
`ifdef GELU_SAT_CNT_EN
      sat_exp += 16;
      checks++;
      if (sat_count !== 16'(sat_exp)) begin
         errors++;
         $display("FAIL sat_count_mixed: got %0d required %0d", sat_count, sat_exp);
      end
`endif
      run_beat(splat(8'h9C), S1, OS16, got, lat);  // x = -100
      checks++;
      if (got !== splat(8'h00)) begin
         errors++;
         $display("FAIL sat_negative: got %h required 0", got);
      end
      @(negedge clk);
`ifdef GELU_SAT_CNT_EN
      checks++;
      if (sat_count !== 16'(sat_exp)) begin
         errors++;
         $display("FAIL sat_count_negative: got %0d required %0d", sat_count, sat_exp);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_zero_identity();
      test_curve();
      test_scale_change();
      test_backpressure();
      test_reset_midstream();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog");
   end

endmodule
